// File: rtl/pll_power_sequencer_pkg.sv
// Shared state encoding and bit positions for the PLL power sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package pll_power_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_LOCKING = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_RUNNING = 4'd3,
    ST_DRAIN   = 4'd4,
    ST_ERROR   = 4'd5
  } pll_state_t;

  // Status byte bit positions; bits [3:0] carry the state encoding.
  localparam int STS_BUSY  = 7;
  localparam int STS_ERROR = 6;
  localparam int STS_LOCK  = 5;
  localparam int STS_PWR   = 4;

  // Control register bit positions.
  localparam int CTL_ENABLE      = 0;
  localparam int CTL_CLEAR_ERROR = 1;

  // Consecutive unlocked cycles in RUNNING that count as a lost lock.
  localparam int LOSS_CYCLES = 4;

  // Busy covers every transitional state.
  function automatic logic is_busy(input pll_state_t s);
    return (s == ST_LOCKING) || (s == ST_SETTLE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/lock_synchronizer.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the oscillator domain.
// Latency: 2 clock edges from input change to output change.
// Backpressure: none.
module lock_synchronizer (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture, both flops cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_power_sequencer.sv
// PLL power/lock sequencer with glitch-free clock-select steering; PLL_SEQ_LOCK_LOSS_EN adds lock-loss recovery.
// Latency: writes land at edge t, FSM reacts at t+1; outputs registered from next-state; response is combinational.
// Backpressure: none; single-cycle write strobes are always accepted.
module pll_power_sequencer
  import pll_power_sequencer_pkg::*;
#(
  parameter int                           NUM_CLOCK_SELECTS   = 2,
  parameter int                           LOCK_TIMEOUT_CYCLES = 4096,
  parameter int                           SWITCH_HOLD_CYCLES  = 8,
  parameter logic [7:0]                   OPCODE_CONTROL      = 8'hA0,
  parameter logic [7:0]                   OPCODE_MASK         = 8'hA1,
  parameter logic [7:0]                   OPCODE_STATUS       = 8'hA2,
  parameter logic [NUM_CLOCK_SELECTS-1:0] RESET_MASK          = '1
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [7:0]                   op_code_in,
  input  logic [7:0]                   operand_in,
  input  logic                         operand_valid_in,
  input  logic                         pll_locked_in,
  output logic [7:0]                   response_out,
  output logic                         pll_powerdown_n_out,
  output logic [NUM_CLOCK_SELECTS-1:0] clock_select_out
);

  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(SWITCH_HOLD_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(SWITCH_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SWITCH_HOLD_CYCLES - 1);

  pll_state_t                   r_state;
  pll_state_t                   w_next;
  logic                         r_enable;
  logic                         r_clear;
  logic [NUM_CLOCK_SELECTS-1:0] r_mask;
  logic [NUM_CLOCK_SELECTS-1:0] r_applied;
  logic [NUM_CLOCK_SELECTS-1:0] r_sel;
  logic                         r_pwr_n;
  logic [TMO_W-1:0]             r_timeout;
  logic [HOLD_W-1:0]            r_hold;
  logic                         w_lock_s;
  logic                         w_ctl_wr;
  logic                         w_mask_wr;
  logic                         w_tmo_clr;
  logic                         w_hold_clr;
  logic                         w_pwr_n_next;
  logic [NUM_CLOCK_SELECTS-1:0] w_sel_next;
  logic [NUM_CLOCK_SELECTS-1:0] w_applied_next;
  logic                         w_loss_evt;
  logic                         w_lock_lost;
  logic [7:0]                   w_status;
  logic                         w_unused_operand;

  lock_synchronizer u_lock_sync (
    .i_clk   (clock_in),
    .i_rst   (reset_in),
    .i_async (pll_locked_in),
    .o_sync  (w_lock_s)
  );

  assign w_ctl_wr  = operand_valid_in && (op_code_in == OPCODE_CONTROL);
  assign w_mask_wr = operand_valid_in && (op_code_in == OPCODE_MASK);
  // Upper operand bits have no meaning for narrow masks.
  assign w_unused_operand = &{1'b0, operand_in};

`ifdef PLL_SEQ_LOCK_LOSS_EN
  localparam int LOSS_W = $clog2(LOSS_CYCLES + 1);
  logic [LOSS_W-1:0] r_loss_cnt;
  logic              r_lock_lost;

  // A disable request takes priority over lock-loss recovery.
  assign w_loss_evt  = (r_state == ST_RUNNING) && r_enable && !w_lock_s &&
                       (r_loss_cnt == LOSS_W'(LOSS_CYCLES - 1));
  assign w_lock_lost = r_lock_lost;

  // Count consecutive unlocked cycles while RUNNING; keep a sticky loss flag.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_loss_cnt  <= '0;
      r_lock_lost <= 1'b0;
    end else begin
      if (r_state != ST_RUNNING || w_lock_s) begin
        r_loss_cnt <= '0;
      end else if (r_loss_cnt != LOSS_W'(LOSS_CYCLES)) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
      if (w_loss_evt) begin
        r_lock_lost <= 1'b1;
      end else if (r_clear) begin
        r_lock_lost <= 1'b0;
      end
    end
  end
`else
  assign w_loss_evt  = 1'b0;
  assign w_lock_lost = 1'b0;
`endif

  // Next-state decode plus the output values that will be registered with it.
  always_comb begin
    w_next     = r_state;
    w_tmo_clr  = 1'b0;
    w_hold_clr = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (r_enable) begin
          w_next    = ST_LOCKING;
          w_tmo_clr = 1'b1;
        end
      end
      ST_LOCKING: begin
        if (w_lock_s) begin
          w_next     = ST_SETTLE;
          w_hold_clr = 1'b1;
        end else if (r_timeout >= TMO_LAST) begin
          w_next = ST_ERROR;
        end
      end
      ST_SETTLE: begin
        if (!w_lock_s) begin
          w_next = ST_LOCKING;
        end else if (r_hold == HOLD_LAST) begin
          w_next = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (!r_enable) begin
          w_next     = ST_DRAIN;
          w_hold_clr = 1'b1;
        end else if (w_loss_evt) begin
          w_next    = ST_LOCKING;
          w_tmo_clr = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_hold == HOLD_LAST) begin
          w_next = ST_OFF;
        end
      end
      ST_ERROR: begin
        if (r_clear) begin
          if (r_enable) begin
            w_next    = ST_LOCKING;
            w_tmo_clr = 1'b1;
          end else begin
            w_next = ST_OFF;
          end
        end
      end
      default: w_next = ST_LOCKING;
    endcase

    w_applied_next = r_applied;
    if (r_state == ST_SETTLE && w_next == ST_RUNNING) begin
      w_applied_next = r_mask;
    end
    w_pwr_n_next = (w_next == ST_LOCKING) || (w_next == ST_SETTLE) ||
                   (w_next == ST_RUNNING) || (w_next == ST_DRAIN);
    w_sel_next   = (w_next == ST_RUNNING) ? w_applied_next : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state   <= ST_LOCKING;
      r_pwr_n   <= 1'b1;
      r_sel     <= '0;
      r_applied <= RESET_MASK;
    end else begin
      r_state   <= w_next;
      r_pwr_n   <= w_pwr_n_next;
      r_sel     <= w_sel_next;
      r_applied <= w_applied_next;
    end
  end

  // Saturating lock timeout, running across LOCKING and SETTLE.
  always_ff @(posedge clock_in) begin
    if (reset_in || w_tmo_clr) begin
      r_timeout <= '0;
    end else if ((r_state == ST_LOCKING || r_state == ST_SETTLE) && r_timeout != TMO_MAX) begin
      r_timeout <= r_timeout + 1'b1;
    end
  end

  // Saturating hold counter shared by SETTLE and DRAIN.
  always_ff @(posedge clock_in) begin
    if (reset_in || w_hold_clr) begin
      r_hold <= '0;
    end else if ((r_state == ST_SETTLE || r_state == ST_DRAIN) && r_hold != HOLD_MAX) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Control and mask registers; clear_error lives for exactly one cycle.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_enable <= 1'b1;
      r_clear  <= 1'b0;
      r_mask   <= RESET_MASK;
    end else begin
      r_clear <= w_ctl_wr && operand_in[CTL_CLEAR_ERROR];
      if (w_ctl_wr) begin
        r_enable <= operand_in[CTL_ENABLE];
      end
      if (w_mask_wr) begin
        r_mask <= operand_in[NUM_CLOCK_SELECTS-1:0];
      end
    end
  end

  always_comb begin
    w_status            = {4'h0, 4'(r_state)};
    w_status[STS_BUSY]  = is_busy(r_state);
    w_status[STS_ERROR] = (r_state == ST_ERROR) || w_lock_lost;
    w_status[STS_LOCK]  = w_lock_s;
    w_status[STS_PWR]   = r_pwr_n;
  end

  assign response_out        = (op_code_in == OPCODE_STATUS) ? w_status : 8'h00;
  assign pll_powerdown_n_out = r_pwr_n;
  assign clock_select_out    = r_sel;

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Self-checking bench: directed scenarios then randomized traffic against a cycle reference model.
// Latency: model advances once per clock edge; outputs compared on the falling edge.
// Backpressure: none.
module tb_pll_power_sequencer;

  localparam int         NCS    = 2;
  localparam int         TMO    = 4096;
  localparam int         HOLD   = 8;
  localparam logic [7:0] OP_CTL = 8'hA0;
  localparam logic [7:0] OP_MSK = 8'hA1;
  localparam logic [7:0] OP_STS = 8'hA2;

  logic           clock_in = 1'b0;
  logic           reset_in;
  logic [7:0]     op_code_in;
  logic [7:0]     operand_in;
  logic           operand_valid_in;
  logic           pll_locked_in;
  logic [7:0]     response_out;
  logic           pll_powerdown_n_out;
  logic [NCS-1:0] clock_select_out;

  int total = 0;
  int bad   = 0;

  always #5 clock_in = ~clock_in;

  pll_power_sequencer #(
    .NUM_CLOCK_SELECTS   (NCS),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .SWITCH_HOLD_CYCLES  (HOLD)
  ) dut (
    .clock_in            (clock_in),
    .reset_in            (reset_in),
    .op_code_in          (op_code_in),
    .operand_in          (operand_in),
    .operand_valid_in    (operand_valid_in),
    .pll_locked_in       (pll_locked_in),
    .response_out        (response_out),
    .pll_powerdown_n_out (pll_powerdown_n_out),
    .clock_select_out    (clock_select_out)
  );

  // Reference model: phase number, edges spent in it, edges since a lock attempt began.
  int       m_state   = 1;
  int       m_since   = 0;
  int       m_tmo     = 0;
  int       m_low     = 0;
  bit       m_en      = 1;
  bit       m_clr     = 0;
  bit       m_lost    = 0;
  bit       m_d1      = 0;
  bit       m_d2      = 0;
  bit [1:0] m_mask    = 2'b11;
  bit [1:0] m_applied = 2'b11;

  task automatic model_step();
    int nxt;
    bit lk;
    bit fresh;
    bit loss;
    lk = m_d2;
    if (reset_in) begin
      m_state = 1; m_since = 0; m_tmo = 0; m_low = 0;
      m_en = 1; m_clr = 0; m_lost = 0; m_d1 = 0; m_d2 = 0;
      m_mask = 2'b11;
      return;
    end
    nxt = m_state; fresh = 0; loss = 0;
    case (m_state)
      0: if (m_en) begin nxt = 1; fresh = 1; end
      1: begin
        if (lk) nxt = 2;
        else if (m_tmo + 1 >= TMO) nxt = 5;
      end
      2: begin
        if (!lk) nxt = 1;
        else if (m_since + 1 == HOLD) begin nxt = 3; m_applied = m_mask; end
      end
      3: begin
        if (!m_en) nxt = 4;
`ifdef PLL_SEQ_LOCK_LOSS_EN
        else if (!lk && m_low + 1 >= 4) begin nxt = 1; fresh = 1; loss = 1; end
`endif
      end
      4: if (m_since + 1 == HOLD) nxt = 0;
      5: if (m_clr) begin nxt = m_en ? 1 : 0; fresh = m_en; end
      default: nxt = 1;
    endcase
    m_low = (m_state == 3 && !lk) ? m_low + 1 : 0;
    if (fresh) m_tmo = 0;
    else if (m_state == 1 || m_state == 2) m_tmo++;
    m_since = (nxt == m_state) ? m_since + 1 : 0;
    if (m_clr) m_lost = 0;
    if (loss) m_lost = 1;
    m_state = nxt;
    m_clr = operand_valid_in && (op_code_in == OP_CTL) && operand_in[1];
    if (operand_valid_in && op_code_in == OP_CTL) m_en = operand_in[0];
    if (operand_valid_in && op_code_in == OP_MSK) m_mask = operand_in[1:0];
    m_d2 = m_d1;
    m_d1 = pll_locked_in;
  endtask

  task automatic check_outputs();
    logic       pd;
    logic [1:0] sel;
    logic [7:0] st;
    logic [7:0] rsp;
    pd  = (m_state >= 1 && m_state <= 4);
    sel = (m_state == 3) ? m_applied : 2'b00;
    st  = {(pd && m_state != 3), (m_state == 5) || m_lost, m_d2, pd, 4'(m_state)};
    rsp = (op_code_in == OP_STS) ? st : 8'h00;
    total++;
    assert (pll_powerdown_n_out === pd) else begin
      bad++; $error("FAIL model_pwr observed=%0b expected=%0b t=%0t", pll_powerdown_n_out, pd, $time);
    end
    total++;
    assert (clock_select_out === sel) else begin
      bad++; $error("FAIL model_sel observed=%0b expected=%0b t=%0t", clock_select_out, sel, $time);
    end
    total++;
    assert (response_out === rsp) else begin
      bad++; $error("FAIL model_rsp observed=%0h expected=%0h t=%0t", response_out, rsp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock_in);
    model_step();
    @(negedge clock_in);
    check_outputs();
  endtask

  task automatic expect8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [7:0] op, input logic [7:0] data);
    op_code_in = op; operand_in = data; operand_valid_in = 1'b1;
    cyc();
    operand_valid_in = 1'b0; op_code_in = OP_STS;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, output int n);
    n = 0;
    while (response_out[3:0] !== st && n < budget) begin
      cyc(); n++;
    end
  endtask

  initial begin
    int n;
    int hold_left;
    reset_in = 1'b1; op_code_in = OP_STS; operand_in = 8'h00;
    operand_valid_in = 1'b0; pll_locked_in = 1'b0;
    repeat (3) cyc();
    reset_in = 1'b0;
    expect8("reset_status", response_out, 8'h91);
    expect8("reset_sel", {6'd0, clock_select_out}, 8'h00);

    // Reset then lock: SETTLE after 10 edges, RUNNING on the 11th.
    repeat (9) cyc();
    pll_locked_in = 1'b1;
    repeat (10) cyc();
    expect8("settle_status", response_out, 8'hB2);
    cyc();
    expect8("run_status", response_out, 8'h33);
    expect8("run_sel", {6'd0, clock_select_out}, 8'h03);

    // Power-down: DRAIN on the next edge, OFF eight edges later.
    pll_locked_in = 1'b0;
    write(OP_CTL, 8'h00);
    cyc();
    expect8("drain_sel", {6'd0, clock_select_out}, 8'h00);
    expect8("drain_state", {4'd0, response_out[3:0]}, 8'h04);
    repeat (8) cyc();
    expect8("off_status", response_out, 8'h00);
    expect8("off_pwr", {7'd0, pll_powerdown_n_out}, 8'h00);

    // Lock timeout from a fresh power-up.
    write(OP_CTL, 8'h01);
    cyc();
    wait_state(4'd5, 5000, n);
    expect8("timeout_edges", n == TMO ? 8'h01 : 8'h00, 8'h01);
    expect8("error_status", response_out, 8'h45);
    write(OP_CTL, 8'h03);
    cyc();
    expect8("clear_to_locking", response_out, 8'h91);

    // Deferred mask.
    pll_locked_in = 1'b1;
    repeat (12) cyc();
    expect8("pre_mask_sel", {6'd0, clock_select_out}, 8'h03);
    write(OP_MSK, 8'h01);
    repeat (3) cyc();
    expect8("mask_deferred", {6'd0, clock_select_out}, 8'h03);
    write(OP_CTL, 8'h00);
    repeat (10) cyc();
    write(OP_CTL, 8'h01);
    repeat (11) cyc();
    expect8("mask_applied", {6'd0, clock_select_out}, 8'h01);

    // Lock glitch during SETTLE forces a full hold again.
    write(OP_CTL, 8'h00);
    repeat (10) cyc();
    pll_locked_in = 1'b0;
    repeat (3) cyc();
    write(OP_CTL, 8'h01);
    cyc();
    pll_locked_in = 1'b1;
    repeat (3) cyc();
    repeat (5) cyc();
    pll_locked_in = 1'b0;
    cyc();
    pll_locked_in = 1'b1;
    wait_state(4'd1, 5, n);
    expect8("glitch_relock", {4'd0, response_out[3:0]}, 8'h01);
    wait_state(4'd3, 40, n);
    expect8("glitch_full_hold", (n >= HOLD) ? 8'h01 : 8'h00, 8'h01);

    // Lock loss while RUNNING.
    pll_locked_in = 1'b0;
    repeat (8) cyc();
`ifdef PLL_SEQ_LOCK_LOSS_EN
    expect8("loss_error_bit", {7'd0, response_out[6]}, 8'h01);
    expect8("loss_sel", {6'd0, clock_select_out}, 8'h00);
`else
    expect8("loss_stays_running", response_out, 8'h13);
`endif
    pll_locked_in = 1'b1;
    write(OP_CTL, 8'h03);

    // Randomized traffic against the model.
    hold_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_left == 0) begin
        pll_locked_in = ~pll_locked_in;
        hold_left = $urandom_range(1, 40);
      end
      hold_left--;
      operand_valid_in = ($urandom_range(0, 15) < 3);
      case ($urandom_range(0, 3))
        0: op_code_in = OP_CTL;
        1: op_code_in = OP_MSK;
        2: op_code_in = OP_STS;
        default: op_code_in = 8'($urandom);
      endcase
      operand_in = 8'($urandom);
      operand_in[0] = ($urandom_range(0, 3) != 0);
      reset_in = ($urandom_range(0, 599) == 0);
      cyc();
    end
    reset_in = 1'b0; operand_valid_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
